// File: rtl/gpio_pkg.sv
// Shared constants and types for the Nexys Video GPIO path.
// Both gpio_input_debounce and the nexys_video_gpio register file use this package.
//   N_SW / N_BTN   : slide-switch and push-button counts on the board
//   DEBOUNCE_10MS  : stable-cycle count equal to 10 ms at 100 MHz
package gpio_pkg;

  localparam int unsigned N_SW          = 8;
  localparam int unsigned N_BTN         = 5;
  localparam int unsigned DEBOUNCE_10MS = 1_000_000;

  typedef logic [N_SW-1:0] gpio_sw_t;

endpackage

// File: rtl/debounce_channel.sv
// Conditions one asynchronous pad input.
// The input passes through a synchroniser, then a consecutive-stable-cycle debouncer.
// Debounced edges are reported as single-cycle pulses.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   raw   : asynchronous pad input
//   level : debounced level
//   rise  : 1-cycle pulse, coincident with level going 0->1
//   fall  : 1-cycle pulse, coincident with level going 1->0
module debounce_channel
  import gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, fall_q;

  // Plain shift chain; no logic between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Counter tracks consecutive cycles of disagreement with the accepted level.
  // It restarts whenever the input returns to that level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/gpio_input_debounce.sv
// Conditions the board switches/buttons for the GPIO register file.
// Each channel is debounced independently. The block adds sticky edge flags and one level interrupt.
//   clk         : system clock (100 MHz)
//   rst         : asynchronous active-high reset
//   i_raw       : asynchronous pad inputs
//   o_level     : debounced levels
//   o_rise      : 1-cycle pulses on debounced 0->1
//   o_fall      : 1-cycle pulses on debounced 1->0
//   o_event     : sticky edge flags
//   i_event_clr : per-flag W1C strobe
//   i_irq_en    : per-channel interrupt enable
//   o_irq       : registered OR of enabled flags
module gpio_input_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned N_CH            = N_SW,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_raw,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_event,
  input  logic [N_CH-1:0] i_event_clr,
  input  logic [N_CH-1:0] i_irq_en,
  output logic            o_irq
);

  logic [N_CH-1:0] event_q, event_d;
  logic            irq_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw   (i_raw[g]),
      .level (o_level[g]),
      .rise  (o_rise[g]),
      .fall  (o_fall[g])
    );
  end

  // The set term is ORed in after the clear, so a new edge wins over a simultaneous W1C.
  always_comb begin
    event_d = (event_q & ~i_event_clr) | o_rise | o_fall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      event_q <= event_d;
      irq_q   <= |(event_q & i_irq_en);
    end
  end

  assign o_event = event_q;
  assign o_irq   = irq_q;

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Self-checking bench for gpio_input_debounce (N_CH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=16).
// The reference model uses a sliding window over the sampled pad history.
// A level is accepted once the last DEBOUNCE_CYCLES synchronised samples all disagree with it.
module tb_gpio_input_debounce;

  localparam int unsigned N_CH = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 16;
  localparam int unsigned HD   = SYNC + DEB;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] raw = '0;
  logic [N_CH-1:0] event_clr = '0;
  logic [N_CH-1:0] irq_en = '0;
  logic [N_CH-1:0] level, rise, fall, evt;
  logic            irq;

  int errors = 0;
  int checks = 0;

  gpio_input_debounce #(
    .N_CH            (N_CH),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_raw       (raw),
    .o_level     (level),
    .o_rise      (rise),
    .o_fall      (fall),
    .o_event     (evt),
    .i_event_clr (event_clr),
    .i_irq_en    (irq_en),
    .o_irq       (irq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // hist[0] is the pad value sampled at the most recent edge.
  // The synchronised sample seen at that edge is hist[SYNC].
  logic [N_CH-1:0] hist [HD];
  logic [N_CH-1:0] m_level = '0, m_rise = '0, m_fall = '0, m_event = '0;
  logic            m_irq = 1'b0;
  logic [N_CH-1:0] all_hi, all_lo, nl;

  initial begin
    for (int i = 0; i < HD; i++) hist[i] = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < HD; i++) hist[i] = '0;
        m_level = '0; m_rise = '0; m_fall = '0; m_event = '0; m_irq = 1'b0;
      end else begin
        for (int i = HD - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = raw;
        all_hi = '1;
        all_lo = '1;
        for (int i = SYNC; i < HD; i++) begin
          all_hi &= hist[i];
          all_lo &= ~hist[i];
        end
        nl      = (m_level & ~all_lo) | (~m_level & all_hi);
        m_irq   = |(m_event & irq_en);
        m_event = (m_event & ~event_clr) | m_rise | m_fall;
        m_rise  = nl & ~m_level;
        m_fall  = ~nl & m_level;
        m_level = nl;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int k;
    bit seen;
    checks++;
    if ({level, rise, fall, evt, irq} !== 33'd0) begin
      errors++;
      $display("FAIL reset_initial: got %h required 0", {level, rise, fall, evt, irq});
    end
    raw = 8'h01;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({level, rise, fall, evt, irq} !== 33'd0) begin
      errors++;
      $display("FAIL reset_midcount: got %h required 0", {level, rise, fall, evt, irq});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    k = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (level[0]) begin
        seen = 1'b1;
        k = i;
      end
    end
    checks++;
    if (!seen || k != 18) begin
      errors++;
      $display("FAIL reset_latency: got %0d cycles (seen=%0d) required 18", k, seen);
    end
    @(negedge clk);
    checks++;
    if ({level, rise, fall, evt, irq} !== {m_level, m_rise, m_fall, m_event, m_irq}) begin
      errors++;
      $display("FAIL reset_model: got %h required %h", {level, rise, fall, evt, irq},
               {m_level, m_rise, m_fall, m_event, m_irq});
    end
  endtask

  task automatic test_clean_press();
    int nr, nf;
    logic [N_CH-1:0] rv, fv;
    raw = '0;
    repeat (22) @(negedge clk);
    event_clr = '1;
    @(negedge clk);
    event_clr = '0;
    nr = 0; rv = '0;
    raw = 8'h01;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      checks++;
      if ({level, rise, fall, evt, irq} !== {m_level, m_rise, m_fall, m_event, m_irq}) begin
        errors++;
        $display("FAIL press_model: got %h required %h", {level, rise, fall, evt, irq},
                 {m_level, m_rise, m_fall, m_event, m_irq});
      end
      if (rise != '0) begin nr++; rv = rise; end
    end
    checks++;
    if (nr != 1 || rv !== 8'h01 || level !== 8'h01 || evt !== 8'h01) begin
      errors++;
      $display("FAIL press_rise: got pulses=%0d rise=%h level=%h event=%h required 1/01/01/01",
               nr, rv, level, evt);
    end
    nf = 0; fv = '0;
    raw = 8'h00;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (fall != '0) begin nf++; fv = fall; end
    end
    checks++;
    if (nf != 1 || fv !== 8'h01 || level !== 8'h00 || evt !== 8'h01) begin
      errors++;
      $display("FAIL press_fall: got pulses=%0d fall=%h level=%h event=%h required 1/01/00/01",
               nf, fv, level, evt);
    end
  endtask

  task automatic test_bounce();
    int nr, nf, k;
    event_clr = '1;
    @(negedge clk);
    event_clr = '0;
    nr = 0; nf = 0; k = 0;
    for (int i = 0; i < 100; i++) begin
      raw[3] = (((i / 5) % 2) == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
      checks++;
      if ({level, rise, fall, evt, irq} !== {m_level, m_rise, m_fall, m_event, m_irq}) begin
        errors++;
        $display("FAIL bounce_model: got %h required %h", {level, rise, fall, evt, irq},
                 {m_level, m_rise, m_fall, m_event, m_irq});
      end
      nr += int'(rise[3]);
      nf += int'(fall[3]);
    end
    raw[3] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (rise[3]) begin nr++; k = i; end
      nf += int'(fall[3]);
    end
    checks++;
    if (nr != 1 || k != 18 || nf != 0 || level[3] !== 1'b1) begin
      errors++;
      $display("FAIL bounce_settle: got rises=%0d at=%0d falls=%0d level=%b required 1/18/0/1",
               nr, k, nf, level[3]);
    end
    raw[3] = 1'b0;
    repeat (22) @(negedge clk);
  endtask

  task automatic test_glitch();
    int nl7, nr;
    raw[7] = 1'b1;
    repeat (15) @(negedge clk);
    raw[7] = 1'b0;
    nl7 = 0; nr = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      nl7 += int'(level[7]);
      nr  += int'(rise[7]) + int'(fall[7]);
    end
    checks++;
    if (nl7 != 0 || nr != 0) begin
      errors++;
      $display("FAIL glitch_15: got level-high cycles=%0d pulses=%0d required 0/0", nl7, nr);
    end
    raw[7] = 1'b1;
    repeat (16) @(negedge clk);
    raw[7] = 1'b0;
    nl7 = 0; nr = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      nl7 += int'(level[7]);
      nr  += int'(rise[7]);
      checks++;
      if ({level, rise, fall, evt, irq} !== {m_level, m_rise, m_fall, m_event, m_irq}) begin
        errors++;
        $display("FAIL glitch_model: got %h required %h", {level, rise, fall, evt, irq},
                 {m_level, m_rise, m_fall, m_event, m_irq});
      end
    end
    checks++;
    if (nl7 == 0 || nr != 1) begin
      errors++;
      $display("FAIL glitch_16: got level-high cycles=%0d rises=%0d required >0/1", nl7, nr);
    end
    repeat (22) @(negedge clk);
  endtask

  task automatic test_w1c_race();
    event_clr = '1;
    @(negedge clk);
    event_clr = '0;
    raw[2] = 1'b1;
    repeat (18) @(negedge clk);
    checks++;
    if (rise[2] !== 1'b1) begin
      errors++;
      $display("FAIL race_rise: got rise[2]=%b required 1", rise[2]);
    end
    event_clr[2] = 1'b1;
    @(negedge clk);
    event_clr = '0;
    checks++;
    if (evt[2] !== 1'b1 || evt !== m_event) begin
      errors++;
      $display("FAIL race_set_wins: got event=%h required %h (bit2=1)", evt, m_event);
    end
    repeat (3) @(negedge clk);
    event_clr[2] = 1'b1;
    @(negedge clk);
    event_clr = '0;
    checks++;
    if (evt[2] !== 1'b0 || evt !== m_event) begin
      errors++;
      $display("FAIL race_lone_clr: got event=%h required %h (bit2=0)", evt, m_event);
    end
  endtask

  task automatic test_irq();
    event_clr = '1;
    @(negedge clk);
    event_clr = '0;
    irq_en = 8'h04;
    raw[2] = 1'b0;
    raw[5] = 1'b1;
    repeat (22) @(negedge clk);
    checks++;
    if (evt[2] !== 1'b1 || evt[5] !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_assert: got event=%h irq=%b required bits2,5 set and irq=1", evt, irq);
    end
    event_clr = 8'h04;
    @(negedge clk);
    event_clr = '0;
    checks++;
    if (evt[2] !== 1'b0 || evt[5] !== 1'b1) begin
      errors++;
      $display("FAIL irq_clr_flag: got event=%h required bit2=0 bit5=1", evt);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0 || irq !== m_irq) begin
      errors++;
      $display("FAIL irq_deassert: got irq=%b required 0", irq);
    end
    irq_en = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 11) == 0) raw[c] = ~raw[c];
      end
      event_clr = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '0;
      if ($urandom_range(0, 49) == 0) irq_en = N_CH'($urandom);
      @(negedge clk);
      checks++;
      if ({level, rise, fall, evt, irq} !== {m_level, m_rise, m_fall, m_event, m_irq}) begin
        errors++;
        $display("FAIL random_model cycle %0d: got %h required %h", i,
                 {level, rise, fall, evt, irq}, {m_level, m_rise, m_fall, m_event, m_irq});
      end
    end
    event_clr = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_w1c_race();
    test_irq();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
